// File: rtl/box_pkg.sv
// box_pkg: FSM states, default geometry, button indices and position helpers for box_motion_ctrl
package box_pkg;
  typedef enum logic [1:0] {S_WAIT, S_MOVE, S_CLAMP} state_t;
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_BOX_W = 100;
  localparam int DEF_BOX_H = 100;
  localparam int DEF_INIT_X = 270;
  localparam int DEF_INIT_Y = 190;
  localparam int BTN_RIGHT = 6;
  localparam int BTN_LEFT = 5;
  localparam int BTN_UP = 3;
  localparam int BTN_DOWN = 4;
  localparam int BTN_MODE = 1;
  function automatic logic signed [11:0] nudge(input logic [9:0] pos, input logic signed [1:0] d, input logic [11:0] s);
    return d == 2'sd1 ? $signed({2'b0, pos} + s) : d == -2'sd1 ? $signed({2'b0, pos} - s) : $signed({2'b0, pos});
  endfunction
  function automatic logic [9:0] clamp(input logic signed [11:0] v, input logic signed [11:0] hi);
    return v < 12'sd0 ? 10'd0 : v > hi ? hi[9:0] : v[9:0];
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: level follows raw only after raw has differed from it for CYCLES consecutive cycles
module btn_debounce #(
  parameter int CYCLES = 250000
) (
  input  logic clk_25mhz,
  input  logic rst_n,
  input  logic raw,
  output logic level
);
  localparam int W = $clog2(CYCLES + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk_25mhz or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      level <= 1'b0;
    end else if (raw == level) cnt <= '0;
    else if (cnt == W'(CYCLES - 1)) begin
      cnt <= '0;
      level <= raw;
    end else cnt <= cnt + 1'b1;
endmodule

// File: rtl/box_motion_ctrl.sv
// box_motion_ctrl: once-per-frame box origin update with debounced buttons, acceleration and edge clamping
// Optional bounce mode built when BOX_BOUNCE_EN is defined.
module box_motion_ctrl import box_pkg::*; #(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int BOX_W = DEF_BOX_W,
  parameter int BOX_H = DEF_BOX_H,
  parameter int INIT_X = DEF_INIT_X,
  parameter int INIT_Y = DEF_INIT_Y,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ACCEL_FRAMES = 30,
  parameter int MAX_STEP = 4
) (
  input  logic       clk_25mhz,
  input  logic       rst_n,
  input  logic [7:0] btn,
  input  logic       vsync,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic       upd,
  output logic       bounce
);
  localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - BOX_W);
  localparam logic signed [11:0] Y_MAX = 12'(SCREEN_H - BOX_H);
  localparam int FW = $clog2(ACCEL_FRAMES + 1);
  localparam int SW = $clog2(MAX_STEP + 1);
  state_t state, nxt;
  logic vsync_q, tick, rt, lt, up, dn;
  logic signed [1:0] dx, dy, mdx, mdy;
  logic [SW-1:0] step, st;
  logic [FW-1:0] frames;
  logic signed [11:0] cx, cy;
  logic [9:0] nx, ny;
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_rt (.clk_25mhz(clk_25mhz), .rst_n(rst_n), .raw(btn[BTN_RIGHT]), .level(rt));
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_lt (.clk_25mhz(clk_25mhz), .rst_n(rst_n), .raw(btn[BTN_LEFT]), .level(lt));
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_up (.clk_25mhz(clk_25mhz), .rst_n(rst_n), .raw(btn[BTN_UP]), .level(up));
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_dn (.clk_25mhz(clk_25mhz), .rst_n(rst_n), .raw(btn[BTN_DOWN]), .level(dn));
  assign tick = vsync & ~vsync_q;
  assign mdx = (rt & ~lt) ? 2'sd1 : (lt & ~rt) ? -2'sd1 : 2'sd0;
  assign mdy = (dn & ~up) ? 2'sd1 : (up & ~dn) ? -2'sd1 : 2'sd0;
  assign st = bounce ? SW'(1) : step;
  assign nx = clamp(cx, X_MAX);
  assign ny = clamp(cy, Y_MAX);
`ifdef BOX_BOUNCE_EN
  logic md, md_q;
  logic signed [1:0] bdx, bdy;
  logic unused;
  assign unused = ^{btn[7], btn[2], btn[0]};
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_md (.clk_25mhz(clk_25mhz), .rst_n(rst_n), .raw(btn[BTN_MODE]), .level(md));
  always_ff @(posedge clk_25mhz or negedge rst_n)
    if (!rst_n) begin
      md_q <= 1'b0;
      bounce <= 1'b0;
      bdx <= 2'sd1;
      bdy <= 2'sd1;
    end else begin
      md_q <= md;
      if (md & ~md_q) begin
        bounce <= ~bounce;
        bdx <= 2'sd1;
        bdy <= 2'sd1;
      end else if (bounce && state == S_CLAMP) begin
        if (nx == 10'd0 || nx == X_MAX[9:0]) bdx <= -bdx;
        if (ny == 10'd0 || ny == Y_MAX[9:0]) bdy <= -bdy;
      end
    end
  assign dx = bounce ? bdx : mdx;
  assign dy = bounce ? bdy : mdy;
`else
  logic unused;
  assign unused = ^{btn[7], btn[2], btn[1], btn[0]};
  assign bounce = 1'b0;
  assign dx = mdx;
  assign dy = mdy;
`endif
  always_ff @(posedge clk_25mhz or negedge rst_n)
    if (!rst_n) state <= S_WAIT;
    else state <= nxt;
  always_comb nxt = state == S_WAIT ? (tick ? S_MOVE : S_WAIT) : state == S_MOVE ? S_CLAMP : S_WAIT;
  always_comb upd = state == S_CLAMP;
  // step used for this frame's move is the pre-increment value
  always_ff @(posedge clk_25mhz or negedge rst_n)
    if (!rst_n) begin
      vsync_q <= 1'b0;
      box_x <= 10'(INIT_X);
      box_y <= 10'(INIT_Y);
      step <= SW'(1);
      frames <= '0;
      cx <= '0;
      cy <= '0;
    end else begin
      vsync_q <= vsync;
      if (state == S_MOVE) begin
        cx <= nudge(box_x, dx, 12'(st));
        cy <= nudge(box_y, dy, 12'(st));
        if (bounce || !(rt | lt | up | dn)) begin
          step <= SW'(1);
          frames <= '0;
        end else if (frames == FW'(ACCEL_FRAMES - 1)) begin
          frames <= '0;
          if (step != SW'(MAX_STEP)) step <= step + 1'b1;
        end else frames <= frames + 1'b1;
      end
      if (state == S_CLAMP) begin
        box_x <= nx;
        box_y <= ny;
      end
    end
endmodule

// File: tb/tb_box_motion_ctrl.sv
// tb_box_motion_ctrl: scoreboard bench for box_motion_ctrl with short debounce and acceleration settings
module tb_box_motion_ctrl;
  logic clk_25mhz = 1'b0, rst_n = 1'b0, vsync = 1'b0, upd, bounce;
  logic [7:0] btn = 8'h00;
  logic [9:0] box_x, box_y;
  logic [19:0] e;
  logic [19:0] exp_q[$];
  int vectors = 0, miscompares = 0;
  int mx = 270, my = 190, mstep = 1, mcnt = 0;
  always #5 clk_25mhz = ~clk_25mhz;
  box_motion_ctrl #(.DEBOUNCE_CYCLES(4), .ACCEL_FRAMES(3)) dut (
    .clk_25mhz(clk_25mhz), .rst_n(rst_n), .btn(btn), .vsync(vsync),
    .box_x(box_x), .box_y(box_y), .upd(upd), .bounce(bounce)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask
  function automatic int clampi(input int v, input int hi);
    return v < 0 ? 0 : v > hi ? hi : v;
  endfunction
  task automatic model_tick();
    int dx, dy;
    dx = (btn[6] && !btn[5]) ? 1 : (btn[5] && !btn[6]) ? -1 : 0;
    dy = (btn[4] && !btn[3]) ? 1 : (btn[3] && !btn[4]) ? -1 : 0;
    mx = clampi(mx + dx * mstep, 540);
    my = clampi(my + dy * mstep, 380);
    if (!(btn[6] || btn[5] || btn[4] || btn[3])) begin
      mstep = 1;
      mcnt = 0;
    end else if (++mcnt == 3) begin
      mcnt = 0;
      if (mstep < 4) mstep++;
    end
    exp_q.push_back({10'(mx), 10'(my)});
  endtask
  task automatic model_reset();
    mx = 270; my = 190; mstep = 1; mcnt = 0;
    exp_q.delete();
  endtask
  task automatic press(input logic [7:0] b);
    @(posedge clk_25mhz); #1 btn = b;
    repeat (8) @(posedge clk_25mhz);
    #1;
  endtask
  task automatic frame();
    int lat;
    @(posedge clk_25mhz); #1 vsync = 1'b1;
    model_tick();
    lat = -1;
    for (int i = 0; i < 8 && lat < 0; i++) begin
      @(negedge clk_25mhz);
      if (upd) lat = i;
    end
    check("upd_latency", lat, 2);
    repeat (2) @(posedge clk_25mhz);
    #1 vsync = 1'b0;
    repeat (4) @(posedge clk_25mhz);
    #1;
  endtask
  always @(negedge clk_25mhz)
    if (rst_n && upd) begin
      @(posedge clk_25mhz); #1;
      if (exp_q.size() == 0) check("spurious_upd", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("box_x", box_x, e[19:10]);
        check("box_y", box_y, e[9:0]);
      end
    end
  initial begin
    repeat (3) @(posedge clk_25mhz);
    #1;
    check("rst_x", box_x, 270);
    check("rst_y", box_y, 190);
    check("rst_upd", upd, 0);
    check("rst_bounce", bounce, 0);
    rst_n = 1'b1;
    press(8'h40);
    @(posedge clk_25mhz); #1 vsync = 1'b1;
    @(posedge clk_25mhz); #1 rst_n = 1'b0;
    #1;
    check("midmove_rst_x", box_x, 270);
    check("midmove_rst_y", box_y, 190);
    check("midmove_rst_upd", upd, 0);
    vsync = 1'b0;
    btn = 8'h00;
    repeat (2) @(posedge clk_25mhz);
    #1 rst_n = 1'b1;
    model_reset();
    repeat (8) @(posedge clk_25mhz);
    frame();
    @(posedge clk_25mhz); #1 btn = 8'h40;
    repeat (3) @(posedge clk_25mhz);
    #1 btn = 8'h00;
    repeat (6) @(posedge clk_25mhz);
    frame();
    check("glitch_x", box_x, 270);
    press(8'h40);
    frame();
    check("debounce_x", box_x, 271);
    repeat (9) frame();
    check("accel_x", box_x, 292);
    press(8'h00);
    frame();
    press(8'h40);
    frame();
    check("restep_x", box_x, 293);
    repeat (70) frame();
    check("clamp_right", box_x, 540);
    press(8'h68);
    repeat (70) frame();
    check("clamp_lr_x", box_x, 540);
    check("clamp_up_y", box_y, 0);
    press(8'h00);
    @(posedge clk_25mhz); #1 rst_n = 1'b0;
    @(posedge clk_25mhz); #1 rst_n = 1'b1;
    model_reset();
    press(8'h50);
    frame();
    check("diag_x", box_x, 271);
    check("diag_y", box_y, 191);
    check("final_bounce", bounce, 0);
    repeat (10) @(posedge clk_25mhz);
    check("queue_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
